// File: rtl/pdm_playback.sv
// PCM-to-PDM playback: fetches signed samples from a capture-style BRAM and
// runs each through a first-order sigma-delta modulator for OSR PDM ticks.
module pdm_playback #(
    parameter int unsigned COUNT_WIDTH  = 14,
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned OSR          = 50,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 m_clk_rising,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 loop,
    input  logic [COUNT_WIDTH:0] length,
    output logic [31:0]          rd_addr,
    output logic                 rd_en,
    input  logic [31:0]          dout,
    output logic                 pdm_out,
    output logic                 busy,
    output logic                 done
);
    localparam int unsigned IW = COUNT_WIDTH + 1;
    localparam int unsigned TW = 10;

    typedef enum logic [1:0] {IDLE, PREFETCH, PLAY} state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           len_q, len_d;
    logic                    loop_q, loop_d;
    logic [IW-1:0]           fetch_idx_q, fetch_idx_d;
    logic [IW-1:0]           play_idx_q, play_idx_d;
    logic [TW-1:0]           tick_q, tick_d;
    logic [SAMPLE_WIDTH:0]   acc_q, acc_d;
    logic [SAMPLE_WIDTH-1:0] cur_q, cur_d;
    logic [SAMPLE_WIDTH-1:0] nxt_q, nxt_d;
    logic [READ_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
    logic [31:0]             rd_addr_q, rd_addr_d;
    logic                    rd_en_q, rd_en_d;
    logic                    pdm_q, pdm_d;
    logic                    done_q, done_d;

    logic [IW-1:0]           fetch_succ;
    logic                    fetch_more;
    logic                    play_last;
    logic                    data_vld;
    logic [SAMPLE_WIDTH-1:0] u;
    logic [SAMPLE_WIDTH:0]   acc_step;
    logic                    unused_dout;

    assign unused_dout = ^dout[31:SAMPLE_WIDTH];

    // The fetch pointer runs one sample ahead of the playing one; once it has
    // reached the last index a non-looping run needs no further reads.
    assign fetch_succ = (fetch_idx_q == len_q - IW'(1)) ? '0 : fetch_idx_q + IW'(1);
    assign fetch_more = (fetch_idx_q != len_q - IW'(1)) || loop_q;
    assign play_last  = (play_idx_q == len_q - IW'(1));
    assign data_vld   = rd_pipe_q[READ_LATENCY-1];

    assign u        = {~cur_q[SAMPLE_WIDTH-1], cur_q[SAMPLE_WIDTH-2:0]};
    assign acc_step = {1'b0, acc_q[SAMPLE_WIDTH-1:0]} + {1'b0, u};

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        loop_d      = loop_q;
        fetch_idx_d = fetch_idx_q;
        play_idx_d  = play_idx_q;
        tick_d      = tick_q;
        acc_d       = acc_q;
        cur_d       = cur_q;
        nxt_d       = nxt_q;
        rd_pipe_d   = READ_LATENCY'({rd_pipe_q, rd_en_q});
        rd_addr_d   = rd_addr_q;
        rd_en_d     = 1'b0;
        pdm_d       = pdm_q;
        done_d      = 1'b0;

        if (stop) begin
            state_d     = IDLE;
            fetch_idx_d = '0;
            play_idx_d  = '0;
            tick_d      = '0;
            acc_d       = '0;
            rd_pipe_d   = '0;
            pdm_d       = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    pdm_d = 1'b0;
                    if (start) begin
                        if (length == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d     = PREFETCH;
                            len_d       = length;
                            loop_d      = loop;
                            fetch_idx_d = '0;
                            play_idx_d  = '0;
                            tick_d      = '0;
                            rd_en_d     = 1'b1;
                            rd_addr_d   = '0;
                        end
                    end
                end
                PREFETCH: begin
                    if (data_vld) begin
                        cur_d   = dout[SAMPLE_WIDTH-1:0];
                        state_d = PLAY;
                        if (fetch_more) begin
                            rd_en_d     = 1'b1;
                            fetch_idx_d = fetch_succ;
                            rd_addr_d   = 32'({fetch_succ[COUNT_WIDTH-1:0], 2'b00});
                        end
                    end
                end
                PLAY: begin
                    if (data_vld) nxt_d = dout[SAMPLE_WIDTH-1:0];
                    if (m_clk_rising) begin
                        acc_d  = acc_step;
                        pdm_d  = acc_step[SAMPLE_WIDTH];
                        tick_d = tick_q + TW'(1);
                        if (tick_q == TW'(OSR - 1)) begin
                            tick_d = '0;
                            // The final bit stays on the pin for one cycle; IDLE then forces it low.
                            if (play_last && !loop_q) begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                                acc_d   = '0;
                            end else begin
                                cur_d      = nxt_q;
                                play_idx_d = play_last ? '0 : play_idx_q + IW'(1);
                                if (fetch_more) begin
                                    rd_en_d     = 1'b1;
                                    fetch_idx_d = fetch_succ;
                                    rd_addr_d   = 32'({fetch_succ[COUNT_WIDTH-1:0], 2'b00});
                                end
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            len_q       <= '0;
            loop_q      <= 1'b0;
            fetch_idx_q <= '0;
            play_idx_q  <= '0;
            tick_q      <= '0;
            acc_q       <= '0;
            cur_q       <= '0;
            nxt_q       <= '0;
            rd_pipe_q   <= '0;
            rd_addr_q   <= '0;
            rd_en_q     <= 1'b0;
            pdm_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            loop_q      <= loop_d;
            fetch_idx_q <= fetch_idx_d;
            play_idx_q  <= play_idx_d;
            tick_q      <= tick_d;
            acc_q       <= acc_d;
            cur_q       <= cur_d;
            nxt_q       <= nxt_d;
            rd_pipe_q   <= rd_pipe_d;
            rd_addr_q   <= rd_addr_d;
            rd_en_q     <= rd_en_d;
            pdm_q       <= pdm_d;
            done_q      <= done_d;
        end
    end

    assign rd_addr = rd_addr_q;
    assign rd_en   = rd_en_q;
    assign pdm_out = pdm_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
endmodule

// File: tb/tb_pdm_playback.sv
// Directed-vector bench for pdm_playback: a 16-bit OSR=4 instance covers
// sequencing, loop, stop and reset; an 8-bit OSR=1 instance covers density.
`timescale 1ns/1ps
module tb_pdm_playback;
    localparam int unsigned A_CW = 4;
    localparam int unsigned B_CW = 8;
    localparam int unsigned STROBE_PERIOD = 6;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        m_clk_rising;
    int unsigned scnt = 0;

    logic          start_a, stop_a, loop_a;
    logic [A_CW:0] len_a;
    logic [31:0]   rd_addr_a, dout_a;
    logic          rd_en_a, pdm_a, busy_a, done_a;
    logic [31:0]   mem_a [0:15];

    logic          start_b, stop_b, loop_b;
    logic [B_CW:0] len_b;
    logic [31:0]   rd_addr_b, dout_b, rd_b1;
    logic          rd_en_b, pdm_b, busy_b, done_b;
    logic [31:0]   mem_b [0:255];

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned done_cnt_a = 0;
    int unsigned done_cnt_b = 0;
    logic [31:0] log_a [$];

    pdm_playback #(.COUNT_WIDTH(A_CW), .SAMPLE_WIDTH(16), .OSR(4), .READ_LATENCY(1)) u_dut_a (
        .clk(clk), .rstn(rstn), .m_clk_rising(m_clk_rising), .start(start_a), .stop(stop_a),
        .loop(loop_a), .length(len_a), .rd_addr(rd_addr_a), .rd_en(rd_en_a), .dout(dout_a),
        .pdm_out(pdm_a), .busy(busy_a), .done(done_a)
    );

    pdm_playback #(.COUNT_WIDTH(B_CW), .SAMPLE_WIDTH(8), .OSR(1), .READ_LATENCY(2)) u_dut_b (
        .clk(clk), .rstn(rstn), .m_clk_rising(m_clk_rising), .start(start_b), .stop(stop_b),
        .loop(loop_b), .length(len_b), .rd_addr(rd_addr_b), .rd_en(rd_en_b), .dout(dout_b),
        .pdm_out(pdm_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) scnt <= (scnt == STROBE_PERIOD - 1) ? 0 : scnt + 1;
    assign m_clk_rising = (scnt == 0);

    always @(posedge clk) begin
        if (rd_en_a) dout_a <= mem_a[rd_addr_a[2 +: A_CW]];
        if (rd_en_b) rd_b1 <= mem_b[rd_addr_b[2 +: B_CW]];
        dout_b <= rd_b1;
    end

    always @(negedge clk) begin
        if (done_a) done_cnt_a++;
        if (done_b) done_cnt_b++;
        if (rd_en_a) log_a.push_back(rd_addr_a);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_strobe();
        int unsigned n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_clk_rising && n < 4 * STROBE_PERIOD);
        if (!m_clk_rising) check("strobe_timeout", 32'd0, 32'd1);
    endtask

    // Leaves the caller at the negedge of the cycle just before a strobe.
    task automatic align_to_strobe();
        int unsigned g = 0;
        while (scnt != STROBE_PERIOD - 1 && g < 2 * STROBE_PERIOD) begin
            @(negedge clk);
            g++;
        end
    endtask

    task automatic start_a_run(input logic [A_CW:0] len, input logic lp);
        align_to_strobe();
        len_a   = len;
        loop_a  = lp;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic collect_a(input int unsigned n, output logic [31:0] bits);
        bits = '0;
        for (int unsigned i = 0; i < n; i++) begin
            wait_strobe();
            @(negedge clk);
            bits = {bits[30:0], pdm_a};
        end
    endtask

    task automatic check_log(input string tag, input int unsigned n, input logic [31:0] exp [5]);
        check({tag, "_count"}, 32'(log_a.size()), 32'(n));
        for (int unsigned i = 0; i < n; i++)
            check($sformatf("%s_addr%0d", tag, i),
                  (i < log_a.size()) ? log_a[i] : 32'hFFFF_FFFF, exp[i]);
    endtask

    task automatic load_three();
        mem_a[0] = 32'h0000_7FFF;
        mem_a[1] = 32'hABCD_8000;
        mem_a[2] = 32'h1234_4000;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bits, b1, b2;
        int unsigned base, ones, alt_err;
        logic [31:0] exp_seq [5];

        start_a = 1'b0; stop_a = 1'b0; loop_a = 1'b0; len_a = '0;
        start_b = 1'b0; stop_b = 1'b0; loop_b = 1'b0; len_b = '0;
        for (int unsigned i = 0; i < 16; i++) mem_a[i] = '0;
        for (int unsigned i = 0; i < 256; i++) mem_b[i] = '0;

        repeat (3) @(negedge clk);
        check("rst_rd_addr", rd_addr_a, 32'd0);
        check("rst_rd_en", 32'(rd_en_a), 32'd0);
        check("rst_pdm", 32'(pdm_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_b_busy", 32'(busy_b), 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Three samples, no loop: 0x7FFF -> 0111, 0x8000 -> 0000, 0x4000 -> 1110.
        load_three();
        log_a.delete();
        start_a_run(3, 1'b0);
        check("start_busy", 32'(busy_a), 32'd1);
        check("start_rd_en", 32'(rd_en_a), 32'd1);
        check("start_rd_addr", rd_addr_a, 32'd0);
        collect_a(12, bits);
        check("play3_bits", bits, 32'h70E);
        check("play3_done", 32'(done_a), 32'd1);
        check("play3_busy", 32'(busy_a), 32'd0);
        repeat (3) @(negedge clk);
        check("play3_pdm_idle", 32'(pdm_a), 32'd0);
        exp_seq = '{32'd0, 32'd4, 32'd8, 32'd0, 32'd0};
        check_log("play3", 3, exp_seq);
        check("play3_done_cnt", 32'(done_cnt_a), 32'd1);

        // Two samples looped: 0x0000 and 0x7FFF with the accumulator carried across wraps.
        mem_a[0] = 32'h0000_0000;
        mem_a[1] = 32'h0000_7FFF;
        log_a.delete();
        base = done_cnt_a;
        start_a_run(2, 1'b1);
        collect_a(14, b1);
        exp_seq = '{32'd0, 32'd4, 32'd0, 32'd4, 32'd0};
        check_log("loop", 5, exp_seq);
        collect_a(6, b2);
        check("loop_bits", ((b1 & 32'h3FFF) << 6) | (b2 & 32'h3F), 32'h57AFA);
        collect_a(2, bits);
        check("loop_bits_tail", bits, 32'h3);
        check("pre_stop_pdm", 32'(pdm_a), 32'd1);

        // stop beats a simultaneous start.
        stop_a = 1'b1; start_a = 1'b1; len_a = 3; loop_a = 1'b0;
        @(negedge clk);
        stop_a = 1'b0; start_a = 1'b0;
        check("stop_busy", 32'(busy_a), 32'd0);
        check("stop_pdm", 32'(pdm_a), 32'd0);
        check("stop_rd_en", 32'(rd_en_a), 32'd0);
        check("stop_done", 32'(done_a), 32'd0);
        log_a.delete();
        repeat (2 * STROBE_PERIOD) @(negedge clk);
        check("stop_no_fetch", 32'(log_a.size()), 32'd0);
        check("stop_still_idle", 32'(busy_a), 32'd0);
        check("loop_stop_no_done", 32'(done_cnt_a), 32'(base));

        // Restart after stop replays from index 0 with a cleared accumulator.
        load_three();
        start_a_run(3, 1'b0);
        check("restart_rd_addr", rd_addr_a, 32'd0);
        check("restart_rd_en", 32'(rd_en_a), 32'd1);
        collect_a(12, bits);
        check("restart_bits", bits, 32'h70E);
        repeat (3) @(negedge clk);
        check("restart_done_cnt", 32'(done_cnt_a), 32'(base + 1));

        // Zero-length start.
        base = done_cnt_a;
        log_a.delete();
        len_a = '0; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("len0_done", 32'(done_a), 32'd1);
        check("len0_busy", 32'(busy_a), 32'd0);
        check("len0_rd_en", 32'(rd_en_a), 32'd0);
        repeat (4) @(negedge clk);
        check("len0_busy_later", 32'(busy_a), 32'd0);
        check("len0_no_fetch", 32'(log_a.size()), 32'd0);
        check("len0_done_cnt", 32'(done_cnt_a), 32'(base + 1));

        // Asynchronous reset in the middle of a sample.
        start_a_run(3, 1'b0);
        collect_a(2, bits);
        check("pre_rst_bits", bits, 32'h1);
        check("pre_rst_rd_addr", rd_addr_a, 32'd4);
        #2 rstn = 1'b0;
        #1;
        check("arst_rd_addr", rd_addr_a, 32'd0);
        check("arst_rd_en", 32'(rd_en_a), 32'd0);
        check("arst_pdm", 32'(pdm_a), 32'd0);
        check("arst_busy", 32'(busy_a), 32'd0);
        check("arst_done", 32'(done_a), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        log_a.delete();
        repeat (3 * STROBE_PERIOD) @(negedge clk);
        check("post_rst_busy", 32'(busy_a), 32'd0);
        check("post_rst_no_fetch", 32'(log_a.size()), 32'd0);
        start_a_run(3, 1'b0);
        check("post_rst_start_busy", 32'(busy_a), 32'd1);
        collect_a(12, bits);
        check("post_rst_bits", bits, 32'h70E);

        // Density: 256 zero samples at OSR=1 give 128 ones, alternating 0/1.
        base = done_cnt_b;
        align_to_strobe();
        len_b = 9'd256; loop_b = 1'b0; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        check("dens_busy", 32'(busy_b), 32'd1);
        ones = 0;
        alt_err = 0;
        for (int unsigned i = 0; i < 256; i++) begin
            wait_strobe();
            @(negedge clk);
            if (pdm_b === 1'b1) ones++;
            if (pdm_b !== i[0]) alt_err++;
        end
        check("dens_ones", 32'(ones), 32'd128);
        check("dens_alternate", 32'(alt_err), 32'd0);
        check("dens_done", 32'(done_b), 32'd1);
        check("dens_busy_end", 32'(busy_b), 32'd0);
        repeat (3) @(negedge clk);
        check("dens_done_cnt", 32'(done_cnt_b), 32'(base + 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
